// File: rtl/jk_register_bank.sv
// WIDTH-bit flip-flop bank with per-bit sync preset/clear and run-time JK/D/T/COUNT modes.
// q updates one edge after inputs; terminal is combinational cascade carry.
module jk_register_bank #(
  parameter int unsigned        WIDTH       = 4,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             input_clock,
  input  logic             input_reset,
  input  logic             input_enable,
  input  logic [1:0]       input_mode,
  input  logic [WIDTH-1:0] input_preset_n,
  input  logic [WIDTH-1:0] input_clear_n,
  input  logic [WIDTH-1:0] input_j,
  input  logic [WIDTH-1:0] input_k,
  input  logic             input_count_down,
  output logic [WIDTH-1:0] output_q,
  output logic [WIDTH-1:0] output_q_n,
  output logic             output_terminal
);

  typedef enum logic [1:0] {
    MODE_JK    = 2'b00,
    MODE_D     = 2'b01,
    MODE_T     = 2'b10,
    MODE_COUNT = 2'b11
  } mode_e;

  mode_e            mode;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] mode_next;
  logic [WIDTH-1:0] count_next;
  logic             count_limit;

  assign mode = mode_e'(input_mode);

  always_comb begin
    count_next = input_count_down ? (q_q - 1'b1) : (q_q + 1'b1);
  end

  // Whole-word mode result; preset/clear then override individual bits without re-carry.
  always_comb begin
    mode_next = q_q;
    unique case (mode)
      MODE_JK:    mode_next = (input_j & ~q_q) | (~input_k & q_q);
      MODE_D:     mode_next = input_j;
      MODE_T:     mode_next = q_q ^ input_j;
      MODE_COUNT: mode_next = count_next;
      default:    mode_next = q_q;
    endcase
  end

  always_comb begin
    q_d = q_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (!input_clear_n[i]) begin
        q_d[i] = 1'b0;
      end else if (!input_preset_n[i]) begin
        q_d[i] = 1'b1;
      end else if (input_enable) begin
        q_d[i] = mode_next[i];
      end
    end
  end

  always_ff @(posedge input_clock) begin
    if (input_reset) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  always_comb begin
    count_limit = input_count_down ? (q_q == '0) : (&q_q);
  end

  assign output_terminal = ~input_reset & input_enable & (mode == MODE_COUNT) & count_limit;
  assign output_q        = q_q;
  assign output_q_n      = ~q_q;

endmodule

// File: tb/tb_jk_register_bank.sv
// Directed self-checking bench for jk_register_bank (WIDTH=4, RESET_VALUE=4'b1010).
module tb_jk_register_bank;

  localparam int unsigned      W  = 4;
  localparam logic [W-1:0]     RV = 4'b1010;

  logic         clk;
  logic         rst;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] preset_n;
  logic [W-1:0] clear_n;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic         cd;
  logic [W-1:0] q;
  logic [W-1:0] q_n;
  logic         term;

  int checks;
  int failures;

  jk_register_bank #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .input_clock      (clk),
    .input_reset      (rst),
    .input_enable     (en),
    .input_mode       (mode),
    .input_preset_n   (preset_n),
    .input_clear_n    (clear_n),
    .input_j          (j),
    .input_k          (k),
    .input_count_down (cd),
    .output_q         (q),
    .output_q_n       (q_n),
    .output_terminal  (term)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] v);
    rst = 1'b0; en = 1'b1; mode = 2'b01; preset_n = '1; clear_n = '1; j = v;
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; en = 1'b1; mode = 2'b11; cd = 1'b0;
    preset_n = 4'($urandom); clear_n = 4'($urandom);
    j = 4'($urandom); k = 4'($urandom);
    #2;

    // 1. Reset
    tick();
    check("reset_q", q, 4'b1010);
    check("reset_qn", q_n, 4'b0101);
    check("reset_term", term, 1'b0);

    // 2. JK truth table
    rst = 1'b0; clear_n = 4'b0000; preset_n = '1;
    tick();
    check("clear_all", q, 4'b0000);
    clear_n = '1; mode = 2'b00; en = 1'b1; j = 4'b1100; k = 4'b1010;
    tick();
    check("jk_1", q, 4'b1100);
    tick();
    check("jk_2", q, 4'b0100);

    // 3. Preset/clear priority
    en = 1'b0; clear_n = 4'b1110; preset_n = 4'b1100;
    tick();
    check("pc_prio", q, 4'b0110);
    clear_n = 4'b1011; preset_n = 4'b1011;
    tick();
    check("pc_both_q", q, 4'b0010);
    check("pc_both_qn", q_n, 4'b1101);

    // 4. Counter wrap and terminal
    load(4'b1110);
    check("load_1110", q, 4'b1110);
    mode = 2'b11; cd = 1'b0;
    #1 check("term_up_1110", term, 1'b0);
    tick();
    check("cnt_up_1111", q, 4'b1111);
    check("term_up_1111", term, 1'b1);
    rst = 1'b1;
    #1 check("term_in_reset", term, 1'b0);
    rst = 1'b0;
    tick();
    check("cnt_up_wrap", q, 4'b0000);
    check("term_up_0000", term, 1'b0);
    load(4'b0001);
    mode = 2'b11; cd = 1'b1;
    tick();
    check("cnt_dn_0000", q, 4'b0000);
    check("term_dn_0000", term, 1'b1);
    en = 1'b0;
    #1 check("term_dis", term, 1'b0);
    en = 1'b1;
    tick();
    check("cnt_dn_wrap", q, 4'b1111);
    check("term_dn_1111", term, 1'b0);

    // Preset during count: bit0 forced, no re-carry from 0011+1=0100
    load(4'b0011);
    mode = 2'b11; cd = 1'b0; preset_n = 4'b1110;
    tick();
    check("cnt_preset", q, 4'b0101);
    preset_n = '1;

    // 5. D/T modes and enable hold
    load(4'b0110);
    check("d_mode", q, 4'b0110);
    mode = 2'b10; j = 4'b0011;
    tick();
    check("t_mode", q, 4'b0101);
    en = 1'b0;
    for (int n = 0; n < 3; n++) begin
      j = 4'($urandom); k = 4'($urandom); mode = 2'($urandom);
      tick();
      check("hold", q, 4'b0101);
    end

    // 6. Reset mid-count
    load(4'b0111);
    mode = 2'b11; cd = 1'b0; rst = 1'b1;
    tick();
    check("mid_reset", q, 4'b1010);
    rst = 1'b0;
    tick();
    check("resume_cnt", q, 4'b1011);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
